// File: rtl/pwm_multi_ip.sv
// Multi-channel PWM peripheral: one prescaled edge/center-aligned counter shared by NUM_CH
// channels, shadowed PERIOD/DUTY reloaded at the period boundary, sticky period-done IRQ.
module pwm_multi_ip #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_we,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(32'hFF);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);

    logic [7:0]        addr;
    logic              en, mode, ie, pd, dir, dir_nxt;
    logic [CNT_W-1:0]  period_sh, period_act, cnt, cnt_nxt;
    logic [PRE_W-1:0]  pre_sh, pre;
    logic [CNT_W-1:0]  duty_sh  [NUM_CH];
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic              wr_ctrl, wr_period, wr_pre, wr_status;
    logic [NUM_CH-1:0] wr_duty;
    logic              tick, boundary;
    logic              unused_bits;

    assign addr        = bus_addr[7:0];
    assign unused_bits = ^{bus_addr[31:8], bus_wdata};
    assign irq         = pd & ie;

    always_comb begin
        wr_ctrl   = bus_we && (addr == 8'h00);
        wr_period = bus_we && (addr == 8'h04);
        wr_pre    = bus_we && (addr == 8'h08);
        wr_status = bus_we && (addr == 8'h0C);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_duty[i] = bus_we && (addr == 8'(16 + 4 * i));
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (addr)
            8'h00:   bus_rdata = {29'b0, ie, mode, en};
            8'h04:   bus_rdata = 32'(period_sh);
            8'h08:   bus_rdata = 32'(pre_sh);
            8'h0C:   bus_rdata = {30'b0, dir, pd};
            default: bus_rdata = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == 8'(16 + 4 * i)) begin
                bus_rdata = 32'(duty_sh[i]);
            end
        end
    end

    // Counter step on each prescaler tick; a period with P_act=0 in center mode degenerates to a
    // boundary on every tick with the counter parked at zero.
    assign tick = en && (pre == pre_sh);

    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else if (tick) begin
            if (!mode) begin
                if (cnt == period_act) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else if (period_act == '0) begin
                cnt_nxt  = '0;
                dir_nxt  = 1'b0;
                boundary = 1'b1;
            end else if (!dir) begin
                if (cnt == period_act) begin
                    dir_nxt = 1'b1;
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else if (cnt == '0) begin
                dir_nxt  = 1'b0;
                cnt_nxt  = CNT_ONE;
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            mode      <= 1'b0;
            ie        <= 1'b0;
            period_sh <= PERIOD_RST;
            pre_sh    <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
        end else begin
            if (wr_ctrl)   {ie, mode, en} <= bus_wdata[2:0];
            if (wr_period) period_sh <= bus_wdata[CNT_W-1:0];
            if (wr_pre)    pre_sh    <= bus_wdata[PRE_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_duty[i]) duty_sh[i] <= bus_wdata[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
            dir <= 1'b0;
        end else begin
            pre <= (!en || tick) ? '0 : pre + PRE_ONE;
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // Active copies track the shadows freely while disabled, otherwise only at a boundary,
    // so a running waveform never sees a half-applied update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act <= PERIOD_RST;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else if (!en || boundary) begin
            period_act <= period_sh;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd      <= 1'b0;
            pwm_out <= '0;
        end else begin
            if (boundary) begin
                pd <= 1'b1;
            end else if (wr_status && bus_wdata[0]) begin
                pd <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= en && (cnt < duty_act[i]);
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_ip.sv
// Self-checking bench for pwm_multi_ip: phase-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized register traffic.
module tb_pwm_multi_ip;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [3:0]  pwm_out;
    logic        irq;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int hi_cnt[4];

    pwm_multi_ip #(.NUM_CH(4), .CNT_W(16), .PRE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .pwm_out(pwm_out), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the counter is tracked as a phase index k within the period, and the
    // counter value and direction are derived from k arithmetically.
    logic        m_en, m_mode, m_ie, m_pd;
    logic [15:0] m_per_sh, m_per_act;
    logic [7:0]  m_pre_sh, m_pc;
    logic [15:0] m_duty_sh[4], m_duty_act[4];
    int          m_k;
    logic [3:0]  m_pwm;
    logic        n_en, n_mode, n_ie, n_pd;
    logic [15:0] n_per_sh, n_per_act;
    logic [7:0]  n_pre_sh, n_pc;
    logic [15:0] n_duty_sh[4], n_duty_act[4];
    int          n_k;
    logic [3:0]  n_pwm;
    int          mc;
    logic        mtick, mbnd;

    function automatic int model_cnt(input logic mode, input int k, input logic [15:0] p);
        if (!mode || k <= int'(p)) return k;
        return 2 * int'(p) - k;
    endfunction

    function automatic logic model_dir(input logic mode, input int k, input logic [15:0] p);
        return mode && (k > int'(p));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[7:0])
            8'h00:   return {29'b0, m_ie, m_mode, m_en};
            8'h04:   return {16'b0, m_per_sh};
            8'h08:   return {24'b0, m_pre_sh};
            8'h0C:   return {30'b0, model_dir(m_mode, m_k, m_per_act), m_pd};
            8'h10:   return {16'b0, m_duty_sh[0]};
            8'h14:   return {16'b0, m_duty_sh[1]};
            8'h18:   return {16'b0, m_duty_sh[2]};
            8'h1C:   return {16'b0, m_duty_sh[3]};
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        n_en = m_en; n_mode = m_mode; n_ie = m_ie; n_pd = m_pd;
        n_per_sh = m_per_sh; n_per_act = m_per_act; n_pre_sh = m_pre_sh; n_pc = m_pc;
        n_duty_sh = m_duty_sh; n_duty_act = m_duty_act; n_k = m_k; n_pwm = '0;
        mtick = 1'b0; mbnd = 1'b0;
        mc = model_cnt(m_mode, m_k, m_per_act);
        for (int i = 0; i < 4; i++) n_pwm[i] = m_en && (mc < int'(m_duty_act[i]));
        if (!m_en) begin
            n_k = 0; n_pc = 8'd0; n_per_act = m_per_sh; n_duty_act = m_duty_sh;
        end else begin
            mtick = (m_pc == m_pre_sh);
            n_pc = mtick ? 8'd0 : m_pc + 8'd1;
            if (mtick) begin
                if (!m_mode) begin
                    if (m_k == int'(m_per_act)) begin mbnd = 1'b1; n_k = 0; end
                    else n_k = m_k + 1;
                end else if (m_per_act == 16'd0) begin
                    mbnd = 1'b1; n_k = 0;
                end else if (m_k == 2 * int'(m_per_act)) begin
                    mbnd = 1'b1; n_k = 1;
                end else begin
                    n_k = m_k + 1;
                end
            end
            if (mbnd) begin
                n_per_act = m_per_sh; n_duty_act = m_duty_sh;
            end
        end
        if (bus_we) begin
            case (bus_addr[7:0])
                8'h00:   {n_ie, n_mode, n_en} = bus_wdata[2:0];
                8'h04:   n_per_sh = bus_wdata[15:0];
                8'h08:   n_pre_sh = bus_wdata[7:0];
                8'h0C:   if (bus_wdata[0]) n_pd = 1'b0;
                8'h10:   n_duty_sh[0] = bus_wdata[15:0];
                8'h14:   n_duty_sh[1] = bus_wdata[15:0];
                8'h18:   n_duty_sh[2] = bus_wdata[15:0];
                8'h1C:   n_duty_sh[3] = bus_wdata[15:0];
                default: ;
            endcase
        end
        if (mbnd) n_pd = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en <= 1'b0; m_mode <= 1'b0; m_ie <= 1'b0; m_pd <= 1'b0;
            m_per_sh <= 16'hFF; m_per_act <= 16'hFF; m_pre_sh <= 8'd0; m_pc <= 8'd0;
            m_duty_sh <= '{default: 16'd0}; m_duty_act <= '{default: 16'd0};
            m_k <= 0; m_pwm <= '0;
        end else begin
            m_en <= n_en; m_mode <= n_mode; m_ie <= n_ie; m_pd <= n_pd;
            m_per_sh <= n_per_sh; m_per_act <= n_per_act; m_pre_sh <= n_pre_sh; m_pc <= n_pc;
            m_duty_sh <= n_duty_sh; m_duty_act <= n_duty_act; m_k <= n_k; m_pwm <= n_pwm;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("model_pwm_out", 32'(pwm_out), 32'(m_pwm));
            check_output("model_irq", 32'(irq), 32'(m_pd & m_ie));
            check_output("model_rdata", bus_rdata, model_read(bus_addr));
        end
    end

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(posedge clk); #1;
        bus_we = 1'b0;
    endtask

    task automatic count_high(input int n);
        for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
        repeat (n) begin
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) hi_cnt[c] += int'(pwm_out[c]);
        end
    endtask

    // Length of the first complete high pulse that starts inside the window.
    task automatic first_high_run(input int ch, input int n, output int len);
        int run = 0;
        bit seen_low = 1'b0;
        bit done = 1'b0;
        len = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (pwm_out[ch]) begin
                if (seen_low) run++;
            end else begin
                if (run > 0 && !done) begin len = run; done = 1'b1; end
                seen_low = 1'b1;
            end
        end
    endtask

    task automatic wait_pd(output int t);
        bit ok = 1'b0;
        t = -1000;
        bus_addr = 32'h0C;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus_rdata[0]) begin ok = 1'b1; t = cyc; break; end
        end
        check_output("pd_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        int t0, t1, t2, len, nv, ai, op;
        int addrs[11] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                          32'h20, 32'h01, 32'h104};

        // Power-on reset values
        repeat (2) @(posedge clk); #1;
        bus_addr = 32'h04; #1;
        check_output("reset_period", bus_rdata, 32'hFF);
        bus_addr = 32'h00; #1;
        check_output("reset_ctrl", bus_rdata, 32'h0);
        check_output("reset_pwm", 32'(pwm_out), 32'h0);
        check_output("reset_irq", 32'(irq), 32'h0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Edge mode, P=9, no prescale
        apply_stimulus(32'h04, 9);
        apply_stimulus(32'h08, 0);
        apply_stimulus(32'h10, 3);
        apply_stimulus(32'h14, 0);
        apply_stimulus(32'h18, 10);
        apply_stimulus(32'h00, 1);
        repeat (12) @(posedge clk); #1;
        count_high(10);
        check_output("edge_ch0_high", hi_cnt[0], 3);
        check_output("edge_ch1_high", hi_cnt[1], 0);
        check_output("edge_ch2_high", hi_cnt[2], 10);

        // Asynchronous reset in the middle of a period
        check_output("ch2_before_reset", 32'(pwm_out[2]), 32'd1);
        bus_addr = 32'h04;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check_output("midrun_reset_pwm", 32'(pwm_out), 32'h0);
        check_output("midrun_reset_irq", 32'(irq), 32'h0);
        check_output("midrun_reset_period", bus_rdata, 32'hFF);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Prescaled edge mode: (4+1)*(3+1) = 20 clocks per period
        apply_stimulus(32'h08, 3);
        apply_stimulus(32'h04, 4);
        apply_stimulus(32'h10, 2);
        apply_stimulus(32'h00, 1);
        repeat (25) @(posedge clk); #1;
        count_high(20);
        check_output("pre_ch0_high", hi_cnt[0], 8);
        wait_pd(t0);
        apply_stimulus(32'h0C, 1);
        wait_pd(t1);
        apply_stimulus(32'h0C, 1);
        wait_pd(t2);
        check_output("pre_pd_interval", t2 - t1, 20);

        // Shadow update of DUTY0 mid-period
        apply_stimulus(32'h00, 0);
        apply_stimulus(32'h08, 0);
        apply_stimulus(32'h04, 9);
        apply_stimulus(32'h10, 3);
        apply_stimulus(32'h0C, 1);
        apply_stimulus(32'h00, 1);
        wait_pd(t1);
        repeat (3) @(posedge clk); #1;
        apply_stimulus(32'h10, 7);
        first_high_run(0, 30, len);
        check_output("shadow_first_pulse", len, 7);

        // Center-aligned, P=8: 16 clocks per period, pulse of 2*D-1 samples around cnt=0
        apply_stimulus(32'h00, 0);
        apply_stimulus(32'h04, 8);
        apply_stimulus(32'h10, 4);
        apply_stimulus(32'h00, 3);
        wait_pd(t0);
        apply_stimulus(32'h0C, 1);
        wait_pd(t1);
        apply_stimulus(32'h0C, 1);
        wait_pd(t2);
        check_output("center_pd_interval", t2 - t1, 16);
        count_high(16);
        check_output("center_ch0_high", hi_cnt[0], 7);
        first_high_run(0, 40, len);
        check_output("center_pulse_len", len, 7);

        // IRQ raise, W1C clear, and clear coincident with a boundary
        apply_stimulus(32'h00, 0);
        apply_stimulus(32'h04, 9);
        apply_stimulus(32'h10, 3);
        apply_stimulus(32'h0C, 1);
        apply_stimulus(32'h00, 5);
        wait_pd(t1);
        check_output("irq_raised", 32'(irq), 32'd1);
        apply_stimulus(32'h0C, 1);
        check_output("irq_cleared", 32'(irq), 32'd0);
        check_output("pd_cleared", 32'(bus_rdata[0]), 32'd0);
        repeat (8) @(posedge clk); #1;
        apply_stimulus(32'h0C, 1);
        check_output("pd_set_wins", 32'(bus_rdata[0]), 32'd1);
        check_output("irq_set_wins", 32'(irq), 32'd1);

        // Randomized register traffic; mode only changes with the counter disabled
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 9);
            ai = $urandom_range(0, 10);
            if (op < 4) begin
                case (addrs[ai])
                    32'h00: begin
                        nv = $urandom_range(0, 7);
                        if (m_en && (nv[1] != m_mode)) apply_stimulus(32'h00, 0);
                        apply_stimulus(32'h00, nv);
                    end
                    32'h04, 32'h104: apply_stimulus(addrs[ai], $urandom_range(0, 20));
                    32'h08: apply_stimulus(32'h08, $urandom_range(0, 3));
                    32'h10, 32'h14, 32'h18, 32'h1C:
                        apply_stimulus(addrs[ai], $urandom_range(0, 22));
                    default: apply_stimulus(addrs[ai], $urandom);
                endcase
            end else begin
                bus_addr = addrs[ai];
                bus_wdata = $urandom;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
